// File: rtl/lc3b_control_pkg.sv
// Shared types for the LC-3b control path: FSM states, ALU ops, opcodes and
// the datapath mux-select encodings driven by lc3b_control.
package lc3b_types;

  typedef enum logic [4:0] {
    s_reset,
    s_fetch1,
    s_fetch2,
    s_fetch3,
    s_decode,
    s_add,
    s_and,
    s_not,
    s_br,
    s_br_taken,
    s_calc_addr,
    s_ldr1,
    s_ldr2,
    s_str1,
    s_str2,
    s_jmp,
    s_lea
  } lc3b_ctrl_state;

  typedef enum logic [1:0] {
    alu_add  = 2'd0,
    alu_and  = 2'd1,
    alu_not  = 2'd2,
    alu_pass = 2'd3
  } lc3b_aluop;

  // Architectural IR[15:12] encodings; unlisted values fall through as NOPs.
  typedef enum logic [3:0] {
    op_br  = 4'b0000,
    op_add = 4'b0001,
    op_and = 4'b0101,
    op_ldr = 4'b0110,
    op_str = 4'b0111,
    op_not = 4'b1001,
    op_jmp = 4'b1100,
    op_lea = 4'b1110
  } lc3b_opcode;

  localparam logic [1:0] PCMUX_PC2      = 2'd0;
  localparam logic [1:0] PCMUX_BR_ADD   = 2'd1;
  localparam logic [1:0] PCMUX_SR1      = 2'd2;

  localparam logic       MARMUX_ALU     = 1'b0;
  localparam logic       MARMUX_PC      = 1'b1;

  localparam logic       MDRMUX_ALU     = 1'b0;
  localparam logic       MDRMUX_MEM     = 1'b1;

  localparam logic [1:0] ALUMUX_SR2     = 2'd0;
  localparam logic [1:0] ALUMUX_IMM5    = 2'd1;
  localparam logic [1:0] ALUMUX_OFFSET6 = 2'd2;

  localparam logic [1:0] RFMUX_ALU      = 2'd0;
  localparam logic [1:0] RFMUX_MDR      = 2'd1;
  localparam logic [1:0] RFMUX_BR_ADD   = 2'd2;

  localparam logic       STOREMUX_SR1   = 1'b0;
  localparam logic       STOREMUX_DEST  = 1'b1;

endpackage

// File: rtl/lc3b_control.sv
// Multicycle LC-3b control FSM: fetch/decode/execute sequencing, outputs are
// decoded from state only (plus imm_bit for ADD/AND operand select).
module lc3b_control
  import lc3b_types::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  lc3b_opcode opcode,
  input  logic       imm_bit,
  input  logic       branch_enable,
  input  logic       mem_resp,
  output logic       load_pc,
  output logic       load_ir,
  output logic       load_regfile,
  output logic       load_mar,
  output logic       load_mdr,
  output logic       load_cc,
  output logic [1:0] pcmux_sel,
  output logic       marmux_sel,
  output logic       mdrmux_sel,
  output logic [1:0] alumux_sel,
  output logic [1:0] regfilemux_sel,
  output logic       storemux_sel,
  output lc3b_aluop  aluop,
  output logic       mem_read,
  output logic       mem_write
);

  lc3b_ctrl_state r_state;
  lc3b_ctrl_state w_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= s_reset;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      s_reset:  w_next = s_fetch1;
      s_fetch1: w_next = s_fetch2;
      s_fetch2: if (mem_resp) w_next = s_fetch3;
      s_fetch3: w_next = s_decode;
      s_decode: begin
        case (opcode)
          op_add:         w_next = s_add;
          op_and:         w_next = s_and;
          op_not:         w_next = s_not;
          op_br:          w_next = s_br;
          op_ldr, op_str: w_next = s_calc_addr;
          op_jmp:         w_next = s_jmp;
          op_lea:         w_next = s_lea;
          default:        w_next = s_fetch1;
        endcase
      end
      s_br:        w_next = branch_enable ? s_br_taken : s_fetch1;
      s_calc_addr: w_next = (opcode == op_ldr) ? s_ldr1 : s_str1;
      s_ldr1:      if (mem_resp) w_next = s_ldr2;
      s_str1:      w_next = s_str2;
      s_str2:      if (mem_resp) w_next = s_fetch1;
      s_add, s_and, s_not, s_br_taken, s_ldr2, s_jmp, s_lea:
                   w_next = s_fetch1;
      default:     w_next = s_reset;
    endcase
  end

  always_comb begin
    load_pc        = 1'b0;
    load_ir        = 1'b0;
    load_regfile   = 1'b0;
    load_mar       = 1'b0;
    load_mdr       = 1'b0;
    load_cc        = 1'b0;
    pcmux_sel      = PCMUX_PC2;
    marmux_sel     = MARMUX_ALU;
    mdrmux_sel     = MDRMUX_ALU;
    alumux_sel     = ALUMUX_SR2;
    regfilemux_sel = RFMUX_ALU;
    storemux_sel   = STOREMUX_SR1;
    aluop          = alu_add;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    case (r_state)
      s_fetch1: begin
        marmux_sel = MARMUX_PC;
        load_mar   = 1'b1;
        pcmux_sel  = PCMUX_PC2;
        load_pc    = 1'b1;
      end
      s_fetch2, s_ldr1: begin
        mem_read   = 1'b1;
        mdrmux_sel = MDRMUX_MEM;
        load_mdr   = 1'b1;
      end
      s_fetch3: load_ir = 1'b1;
      s_add, s_and: begin
        aluop          = (r_state == s_add) ? alu_add : alu_and;
        alumux_sel     = imm_bit ? ALUMUX_IMM5 : ALUMUX_SR2;
        load_regfile   = 1'b1;
        load_cc        = 1'b1;
        regfilemux_sel = RFMUX_ALU;
      end
      s_not: begin
        aluop        = alu_not;
        load_regfile = 1'b1;
        load_cc      = 1'b1;
      end
      s_br_taken: begin
        pcmux_sel = PCMUX_BR_ADD;
        load_pc   = 1'b1;
      end
      s_calc_addr: begin
        alumux_sel = ALUMUX_OFFSET6;
        aluop      = alu_add;
        marmux_sel = MARMUX_ALU;
        load_mar   = 1'b1;
      end
      s_ldr2: begin
        regfilemux_sel = RFMUX_MDR;
        load_regfile   = 1'b1;
        load_cc        = 1'b1;
      end
      s_str1: begin
        storemux_sel = STOREMUX_DEST;
        aluop        = alu_pass;
        mdrmux_sel   = MDRMUX_ALU;
        load_mdr     = 1'b1;
      end
      s_str2: mem_write = 1'b1;
      s_jmp: begin
        pcmux_sel = PCMUX_SR1;
        load_pc   = 1'b1;
      end
      s_lea: begin
        regfilemux_sel = RFMUX_BR_ADD;
        load_regfile   = 1'b1;
        load_cc        = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lc3b_control.sv
// Directed bench for lc3b_control: walks each instruction class through the
// FSM and compares the packed control outputs against hand-written vectors.
module tb_lc3b_control;
  import lc3b_types::*;

  logic       clk;
  logic       rst_n;
  lc3b_opcode opcode;
  logic       imm_bit;
  logic       branch_enable;
  logic       mem_resp;
  logic       load_pc, load_ir, load_regfile, load_mar, load_mdr, load_cc;
  logic [1:0] pcmux_sel;
  logic       marmux_sel;
  logic       mdrmux_sel;
  logic [1:0] alumux_sel;
  logic [1:0] regfilemux_sel;
  logic       storemux_sel;
  lc3b_aluop  aluop;
  logic       mem_read, mem_write;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int c0;

  lc3b_control dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .opcode         (opcode),
    .imm_bit        (imm_bit),
    .branch_enable  (branch_enable),
    .mem_resp       (mem_resp),
    .load_pc        (load_pc),
    .load_ir        (load_ir),
    .load_regfile   (load_regfile),
    .load_mar       (load_mar),
    .load_mdr       (load_mdr),
    .load_cc        (load_cc),
    .pcmux_sel      (pcmux_sel),
    .marmux_sel     (marmux_sel),
    .mdrmux_sel     (mdrmux_sel),
    .alumux_sel     (alumux_sel),
    .regfilemux_sel (regfilemux_sel),
    .storemux_sel   (storemux_sel),
    .aluop          (aluop),
    .mem_read       (mem_read),
    .mem_write      (mem_write)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed layout: lpc lir lrf lmar lmdr lcc pcm[2] marm mdrm alum[2] rfm[2] stm aop[2] mr mw
  localparam logic [18:0] ZERO = 19'd0;
  localparam logic [18:0] LPC  = 19'd1 << 18;
  localparam logic [18:0] LIR  = 19'd1 << 17;
  localparam logic [18:0] LRF  = 19'd1 << 16;
  localparam logic [18:0] LMAR = 19'd1 << 15;
  localparam logic [18:0] LMDR = 19'd1 << 14;
  localparam logic [18:0] LCC  = 19'd1 << 13;
  localparam logic [18:0] MARM = 19'd1 << 10;
  localparam logic [18:0] MDRM = 19'd1 << 9;
  localparam logic [18:0] STM  = 19'd1 << 4;
  localparam logic [18:0] MR   = 19'd1 << 1;
  localparam logic [18:0] MW   = 19'd1;

  function automatic logic [18:0] pcm(input logic [1:0] v);
    return 19'(v) << 11;
  endfunction
  function automatic logic [18:0] alum(input logic [1:0] v);
    return 19'(v) << 7;
  endfunction
  function automatic logic [18:0] rfm(input logic [1:0] v);
    return 19'(v) << 5;
  endfunction
  function automatic logic [18:0] aop(input logic [1:0] v);
    return 19'(v) << 2;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [18:0] exp);
    logic [18:0] obs;
    obs = {load_pc, load_ir, load_regfile, load_mar, load_mdr, load_cc,
           pcmux_sel, marmux_sel, mdrmux_sel, alumux_sel, regfilemux_sel,
           storemux_sel, 2'(aluop), mem_read, mem_write};
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkv(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Starts sampled in FETCH1, ends sampled in the first execute state.
  task automatic fetch(input lc3b_opcode op, input int waits);
    int rd;
    rd = 0;
    chk("fetch1", LMAR | MARM | LPC);
    tick();
    for (int i = 0; i < waits; i++) begin
      chk("fetch2_wait", MR | MDRM | LMDR);
      rd += int'(mem_read);
      tick();
    end
    mem_resp = 1'b1;
    chk("fetch2_resp", MR | MDRM | LMDR);
    rd += int'(mem_read);
    tick();
    mem_resp = 1'b0;
    chkv("fetch_read_cycles", rd, waits + 1);
    chk("fetch3", LIR);
    opcode = op;
    tick();
    chk("decode", ZERO);
    tick();
  endtask

  initial begin
    rst_n = 1'b0; opcode = op_br; imm_bit = 1'b0;
    branch_enable = 1'b0; mem_resp = 1'b0;
    #3;
    chk("reset_outputs", ZERO);
    #9;
    rst_n = 1'b1;
    chk("reset_released", ZERO);
    tick();

    // ADD immediate with a 3-cycle memory wait, imm_bit steering checked live
    c0 = cyc; imm_bit = 1'b1;
    fetch(op_add, 3);
    chk("s_add_imm", LRF | LCC | alum(2'd1) | aop(2'(alu_add)));
    imm_bit = 1'b0;
    #1;
    chk("s_add_reg", LRF | LCC | alum(2'd0) | aop(2'(alu_add)));
    tick();
    chkv("add_cycles", cyc - c0, 8);

    c0 = cyc;
    fetch(op_and, 0);
    chk("s_and", LRF | LCC | aop(2'(alu_and)));
    tick();
    chkv("and_cycles", cyc - c0, 5);

    c0 = cyc;
    fetch(op_not, 0);
    chk("s_not", LRF | LCC | aop(2'(alu_not)));
    tick();
    chkv("not_cycles", cyc - c0, 5);

    c0 = cyc;
    fetch(op_br, 0);
    chk("s_br_nt", ZERO);
    tick();
    chkv("br_nt_cycles", cyc - c0, 5);

    c0 = cyc; branch_enable = 1'b1;
    fetch(op_br, 0);
    chk("s_br_t", ZERO);
    tick();
    branch_enable = 1'b0;
    chk("br_taken", pcm(2'd1) | LPC);
    tick();
    chkv("br_t_cycles", cyc - c0, 6);

    c0 = cyc;
    fetch(op_jmp, 0);
    chk("s_jmp", pcm(2'd2) | LPC);
    tick();
    chkv("jmp_cycles", cyc - c0, 5);

    c0 = cyc;
    fetch(op_lea, 0);
    chk("s_lea", rfm(2'd2) | LRF | LCC);
    tick();
    chkv("lea_cycles", cyc - c0, 5);

    // LDR with one wait; a stray mem_resp in CALC_ADDR must be ignored
    c0 = cyc;
    fetch(op_ldr, 0);
    mem_resp = 1'b1;
    chk("ldr_calc", LMAR | alum(2'd2) | aop(2'(alu_add)));
    tick();
    mem_resp = 1'b0;
    chk("ldr1_wait", MR | MDRM | LMDR);
    tick();
    mem_resp = 1'b1;
    chk("ldr1_resp", MR | MDRM | LMDR);
    tick();
    mem_resp = 1'b0;
    chk("ldr2", rfm(2'd1) | LRF | LCC);
    tick();
    chkv("ldr_cycles", cyc - c0, 8);

    c0 = cyc;
    fetch(op_str, 0);
    chk("str_calc", LMAR | alum(2'd2) | aop(2'(alu_add)));
    tick();
    chk("str1", STM | aop(2'(alu_pass)) | LMDR);
    tick();
    for (int i = 0; i < 2; i++) begin
      chk("str2_wait", MW);
      tick();
    end
    mem_resp = 1'b1;
    chk("str2_resp", MW);
    tick();
    mem_resp = 1'b0;
    chkv("str_cycles", cyc - c0, 9);

    c0 = cyc;
    fetch(lc3b_opcode'(4'b1000), 0);
    chkv("nop_cycles", cyc - c0, 4);

    // Reset asserted in LDR1 before the response arrives
    fetch(op_ldr, 0);
    chk("ldr_calc_2", LMAR | alum(2'd2) | aop(2'(alu_add)));
    tick();
    chk("ldr1_pre_reset", MR | MDRM | LMDR);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_reset_drop", ZERO);
    tick();
    chk("reset_held", ZERO);
    #2;
    rst_n = 1'b1;
    chk("reset_state", ZERO);
    tick();
    chk("restart_fetch1", LMAR | MARM | LPC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
